matrix_frame_capture: RTL and testbench
=======================================

# matrix_frame_capture

Receiving end of the 8x8 LED-matrix serial interface: watches the shift-register control lines (shcp, stcp, mr, oe, ds) and the row-select bus that the matrix converter drives, and rebuilds the displayed 8x8 frame. Used as an on-chip loopback checker and as the bench-side monitor for the game/pattern logic. It models the 74HC595 column chain: shift on shcp, latch on stcp, clear on mr, output gated by oe. It emits a complete frame once every row has been latched.

## Interface
Parameters:
- COL_ACTIVE_LOW, 1: column bits on the wire are active-low; inverted before storing so frame bit 1 = LED lit.
- BITS_PER_ROW, 8: shcp edges expected between consecutive stcp rising edges.

Ports:
- clk  in  1  system clock; all inputs are synchronous to it.
- reset  in  1  synchronous, active-high.
- shcp  in  1  shift clock, level signal; rising edge sampled in clk domain.
- stcp  in  1  storage/latch clock, level signal; rising edge sampled.
- mr  in  1  master reset of shift chain, active-low.
- oe  in  1  output enable, active-low.
- ds  in  1  serial column data.
- rowsIn  in  8  row select; bit r high = row r driven.
- frame  out  64  logic [7:0][7:0]; frame[r][c] = row r, column c lit.
- frame_valid  out  1  one-cycle pulse when frame updates.
- row_err  out  1  one-cycle pulse: latch with oe low and rowsIn not one-hot.
- bits_err  out  1  one-cycle pulse: latch after shcp edge count ≠ BITS_PER_ROW.

## Operation
- Edge detect: shcp_q/stcp_q registered; rise = in & ~in_q. During reset, shcp_q <= shcp and stcp_q <= stcp, so no false edge at reset release.
- Shift register sr[7:0]: on shcp rise, sr <= {sr[6:0], ds}. The first bit shifted lands in sr[7], so the column order is MSB first.
- mr low: sr <= 0 and bit_cnt <= 0. This takes priority over a shift in the same cycle.
- bit_cnt (4 bits, saturates at 15): increments on each shcp rise.
- On stcp rise:
  - store <= sr, using the pre-shift value if shcp rises in the same cycle.
  - bits_err pulses if bit_cnt ≠ BITS_PER_ROW.
  - bit_cnt <= 0, or 1 if shcp rises in the same cycle.
- Row capture: evaluated on the stcp rise cycle using that cycle's oe and rowsIn.
  - oe high: no capture, no row_err.
  - oe low, rowsIn one-hot with index r: work[r] <= sr (inverted if COL_ACTIVE_LOW), and mask[r] <= 1.
  - oe low, rowsIn zero or multi-hot: row_err pulses; work and mask unchanged.
- Repeated row before frame completion: work[r] is overwritten and mask is unchanged.
- Completion: when mask becomes 8'hFF:
  - frame <= work, including the row written in the completing capture.
  - frame_valid pulses.
  - mask <= 0.
- Reset values: sr, store, work, mask, bit_cnt, frame = 0; frame_valid, row_err, bits_err = 0.
- Reset asserted mid-frame: everything is cleared in that cycle and the partial frame is discarded.

## Timing
- shcp/stcp rise present at the input in cycle N: edge detected in N, sr/store/work updated at the end of N.
- frame and frame_valid change at the end of cycle N+1, i.e. one register stage after the completing capture.
- row_err and bits_err are asserted at the end of cycle N, lasting one cycle each.
- frame holds its value until the next completion.
- Minimum input pulse width: 1 clk high and 1 clk low. Narrower pulses are undefined.
- Back-to-back stcp rises on alternate cycles are supported; capture throughput is one row per 2 cycles.

## Structure
- Shared package matrix_pkg:
  - ROWS = 8 and COLS = 8.
  - typedef frame_t = logic [7:0][7:0].
  - function onehot8_idx(logic [7:0]) returning {valid, idx[2:0]}.
- Sub-module sr595_model: edge detection, sr, store, bit_cnt, mr/oe handling. Outputs latch_pulse, latched_row, oe_n, bits_err.
- Top level contains the row-capture and frame-assembly logic.

## Test plan
- Row sweep: for r = 0..7, shift 8 bits of ~(8'h01<<r) MSB first, rowsIn = 1<<r, oe = 0, then stcp → one frame_valid after the 8th latch; frame[r] = 8'h01<<r for every r.
- Partial frame then reset: latch rows 0–5, assert reset 1 cycle, then send a full frame of 8'hAA → frame = all 8'hAA with exactly one frame_valid; no stale row data.
- Malformed latch: rowsIn = 8'h03 with oe = 0 at stcp → row_err for 1 cycle, mask unchanged. rowsIn = 8'h00 → row_err. oe = 1 with rowsIn = 8'h03 → no row_err.
- Bit-count error: 7 shcp edges then stcp → bits_err pulse; data still captured. mr = 0 between rows → next latch captures 8'hFF (inverted 0).
- Duplicate row: latch row 2 = 8'h0F then row 2 = 8'hF0, then remaining rows → frame[2] = 8'hF0, one frame_valid.
- Simultaneous shcp and stcp rise: sr = 8'h5A, ds = 1 → store = 8'h5A and sr = 8'hB5 afterwards, bit_cnt = 1.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared types and helpers for the LED-matrix frame capture path.
package matrix_pkg;

  localparam int ROWS = 8;
  localparam int COLS = 8;

  typedef logic [ROWS-1:0][COLS-1:0] frame_t;

  // Returns {valid, idx}; valid is set only when exactly one bit of v is high.
  function automatic logic [3:0] onehot8_idx(input logic [7:0] v);
    logic [3:0] res;
    logic [7:0] probe;
    res = 4'b0;
    for (int i = 0; i < 8; i++) begin
      probe = 8'h01 << i;
      if (v == probe) res = {1'b1, 3'(i)};
    end
    return res;
  endfunction

endpackage

// File: rtl/matrix_frame_capture_if.sv
// Serial matrix bus as seen by the capture block: 595 control lines, row select, rebuilt frame.
interface matrix_frame_capture_if;
  import matrix_pkg::*;

  logic       shcp;
  logic       stcp;
  logic       mr;
  logic       oe;
  logic       ds;
  logic [7:0] rowsIn;
  frame_t     frame;
  logic       frame_valid;
  logic       row_err;
  logic       bits_err;

  modport master (
    output shcp, stcp, mr, oe, ds, rowsIn,
    input  frame, frame_valid, row_err, bits_err
  );

  modport slave (
    input  shcp, stcp, mr, oe, ds, rowsIn,
    output frame, frame_valid, row_err, bits_err
  );

endinterface

// File: rtl/sr595_model.sv
// Behavioural model of one 74HC595 column chain, sampled in the clk domain.
module sr595_model
  import matrix_pkg::*;
#(
  parameter int BITS_PER_ROW = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       shcp,
  input  logic       stcp,
  input  logic       mr,
  input  logic       oe,
  input  logic       ds,
  output logic       latch_pulse,
  output logic [7:0] latched_row,
  output logic       oe_n,
  output logic       bits_err
);

  localparam logic [3:0] BPR = 4'(BITS_PER_ROW);

  logic       shcp_q, stcp_q;
  logic [7:0] sr_q, sr_d;
  logic [7:0] store_q, store_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic       bits_err_q, bits_err_d;
  logic       shcp_rise, stcp_rise;

  assign shcp_rise = shcp & ~shcp_q;
  assign stcp_rise = stcp & ~stcp_q;

  always_comb begin
    sr_d       = sr_q;
    store_d    = store_q;
    bit_cnt_d  = bit_cnt_q;
    bits_err_d = 1'b0;

    // The latch sees sr before any shift landing in the same cycle.
    if (stcp_rise) begin
      store_d    = sr_q;
      bits_err_d = (bit_cnt_q != BPR);
    end

    if (!mr) begin
      sr_d      = '0;
      bit_cnt_d = '0;
    end else begin
      if (shcp_rise) sr_d = {sr_q[6:0], ds};
      if (stcp_rise) begin
        bit_cnt_d = {3'b000, shcp_rise};
      end else if (shcp_rise && bit_cnt_q != 4'hF) begin
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shcp_q     <= shcp;
      stcp_q     <= stcp;
      sr_q       <= '0;
      store_q    <= '0;
      bit_cnt_q  <= '0;
      bits_err_q <= 1'b0;
    end else begin
      shcp_q     <= shcp;
      stcp_q     <= stcp;
      sr_q       <= sr_d;
      store_q    <= store_d;
      bit_cnt_q  <= bit_cnt_d;
      bits_err_q <= bits_err_d;
    end
  end

  assign latch_pulse = stcp_rise;
  assign latched_row = store_d;
  assign oe_n        = oe;
  assign bits_err    = bits_err_q;

endmodule

// File: rtl/matrix_frame_capture.sv
// Rebuilds the 8x8 LED frame from the row-select bus and the 595 column chain.
module matrix_frame_capture
  import matrix_pkg::*;
#(
  parameter bit COL_ACTIVE_LOW = 1'b1,
  parameter int BITS_PER_ROW   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  matrix_frame_capture_if.slave bus
);

  logic       latch_pulse;
  logic [7:0] latched_row;
  logic       oe_n;
  logic       chain_bits_err;

  sr595_model #(
    .BITS_PER_ROW(BITS_PER_ROW)
  ) u_sr595 (
    .clk        (clk),
    .reset      (reset),
    .shcp       (bus.shcp),
    .stcp       (bus.stcp),
    .mr         (bus.mr),
    .oe         (bus.oe),
    .ds         (bus.ds),
    .latch_pulse(latch_pulse),
    .latched_row(latched_row),
    .oe_n       (oe_n),
    .bits_err   (chain_bits_err)
  );

  frame_t     work_q, work_d;
  frame_t     frame_q, frame_d;
  logic [7:0] mask_q, mask_d;
  logic       frame_valid_q, frame_valid_d;
  logic       row_err_q, row_err_d;
  logic [3:0] sel;
  logic       capture;
  logic       complete;
  logic [7:0] row_data;

  always_comb begin
    sel       = onehot8_idx(bus.rowsIn);
    capture   = latch_pulse & ~oe_n & sel[3];
    row_err_d = latch_pulse & ~oe_n & ~sel[3];
    row_data  = COL_ACTIVE_LOW ? ~latched_row : latched_row;
    complete  = (mask_q == 8'hFF);

    work_d        = work_q;
    mask_d        = mask_q;
    frame_d       = frame_q;
    frame_valid_d = 1'b0;

    // A full mask is published one stage after the capture that filled it.
    if (complete) begin
      frame_d       = work_q;
      frame_valid_d = 1'b1;
      mask_d        = '0;
    end

    if (capture) begin
      work_d[sel[2:0]] = row_data;
      mask_d[sel[2:0]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      work_q        <= '0;
      mask_q        <= '0;
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
      row_err_q     <= 1'b0;
    end else begin
      work_q        <= work_d;
      mask_q        <= mask_d;
      frame_q       <= frame_d;
      frame_valid_q <= frame_valid_d;
      row_err_q     <= row_err_d;
    end
  end

  assign bus.frame       = frame_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.row_err     = row_err_q;
  assign bus.bits_err    = chain_bits_err;

endmodule

// File: tb/tb_matrix_frame_capture.sv
// Randomized bench for matrix_frame_capture against a row/mask/frame reference model.
module tb_matrix_frame_capture;
  import matrix_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  matrix_frame_capture_if bus ();

  matrix_frame_capture #(
    .COL_ACTIVE_LOW(1'b1),
    .BITS_PER_ROW  (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;
  int fv_cnt = 0, re_cnt = 0, be_cnt = 0;

  always @(negedge clk) begin
    if (bus.frame_valid === 1'b1) fv_cnt <= fv_cnt + 1;
    if (bus.row_err === 1'b1)     re_cnt <= re_cnt + 1;
    if (bus.bits_err === 1'b1)    be_cnt <= be_cnt + 1;
  end

  // Reference model state
  logic [7:0] m_sr;
  int         m_cnt;
  logic [7:0] m_work [8];
  logic [7:0] m_mask;
  frame_t     m_frame;
  int         exp_fv = 0, exp_re = 0, exp_be = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mdl_clear();
    m_sr = '0;
    m_cnt = 0;
    for (int i = 0; i < 8; i++) m_work[i] = '0;
    m_mask = '0;
    m_frame = '0;
  endtask

  task automatic mdl_step(input bit sh, input bit st);
    int r;
    if (st) begin
      if (m_cnt != 8) exp_be++;
      if (!bus.oe) begin
        if ($countones(bus.rowsIn) == 1) begin
          r = $clog2(bus.rowsIn);
          m_work[r] = ~m_sr;
          m_mask[r] = 1'b1;
          if (m_mask == 8'hFF) begin
            for (int i = 0; i < 8; i++) m_frame[i] = m_work[i];
            exp_fv++;
            m_mask = '0;
          end
        end else begin
          exp_re++;
        end
      end
      m_cnt = sh ? 1 : 0;
    end
    if (sh) begin
      m_sr = {m_sr[6:0], bus.ds};
      if (!st && m_cnt < 15) m_cnt++;
    end
  endtask

  task automatic drive_cycle(input bit sh, input bit st);
    bus.shcp = sh;
    bus.stcp = st;
    mdl_step(sh, st);
    tick();
    bus.shcp = 1'b0;
    bus.stcp = 1'b0;
    tick();
  endtask

  task automatic shift_byte(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      bus.ds = v[7-i];
      drive_cycle(1'b1, 1'b0);
    end
  endtask

  task automatic latch(input logic [7:0] rows, input bit oe_v);
    bus.rowsIn = rows;
    bus.oe = oe_v;
    drive_cycle(1'b0, 1'b1);
  endtask

  // Sends a lit-pattern for one row: wire data is the inverse of the lit bits.
  task automatic send_row(input int r, input logic [7:0] lit);
    shift_byte(~lit, 8);
    latch(8'h01 << r, 1'b0);
  endtask

  task automatic settle();
    tick();
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mdl_clear();
    tick();
  endtask

  task automatic test_reset();
    bus.shcp = 1'b1;
    bus.stcp = 1'b1;
    bus.mr = 1'b1;
    bus.oe = 1'b0;
    bus.ds = 1'b0;
    bus.rowsIn = 8'h01;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    mdl_clear();
    tick();
    bus.shcp = 1'b0;
    bus.stcp = 1'b0;
    settle();
    checks++;
    if (bus.frame !== '0) begin
      failures++;
      $display("FAIL reset_frame got=%h want=0", bus.frame);
    end
    checks++;
    if ({bus.frame_valid, bus.row_err, bus.bits_err} !== 3'b000) begin
      failures++;
      $display("FAIL reset_pulses got=%b want=000", {bus.frame_valid, bus.row_err, bus.bits_err});
    end
    checks++;
    if (be_cnt !== exp_be || re_cnt !== exp_re) begin
      failures++;
      $display("FAIL reset_false_edge be=%0d re=%0d want be=%0d re=%0d", be_cnt, re_cnt, exp_be, exp_re);
    end
  endtask

  task automatic test_row_sweep();
    int fv0;
    fv0 = fv_cnt;
    for (int r = 0; r < 7; r++) send_row(r, 8'h01 << r);
    shift_byte(~8'h80, 8);
    bus.rowsIn = 8'h80;
    bus.oe = 1'b0;
    bus.stcp = 1'b1;
    mdl_step(1'b0, 1'b1);
    tick();
    checks++;
    if (bus.frame_valid !== 1'b0) begin
      failures++;
      $display("FAIL sweep_fv_early got=%b want=0", bus.frame_valid);
    end
    bus.stcp = 1'b0;
    tick();
    checks++;
    if (bus.frame_valid !== 1'b1) begin
      failures++;
      $display("FAIL sweep_fv_timing got=%b want=1", bus.frame_valid);
    end
    for (int r = 0; r < 8; r++) begin
      checks++;
      if (bus.frame[r] !== (8'h01 << r)) begin
        failures++;
        $display("FAIL sweep_row%0d got=%h want=%h", r, bus.frame[r], 8'h01 << r);
      end
    end
    settle();
    checks++;
    if (bus.frame_valid !== 1'b0 || fv_cnt - fv0 !== 1) begin
      failures++;
      $display("FAIL sweep_fv_count got=%0d want=1", fv_cnt - fv0);
    end
  endtask

  task automatic test_random_frames();
    int order [8];
    int j, t;
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 8; i++) order[i] = i;
      for (int i = 7; i > 0; i--) begin
        j = $urandom_range(i, 0);
        t = order[i];
        order[i] = order[j];
        order[j] = t;
      end
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(3, 0) == 0) begin
          shift_byte(8'($urandom), 8);
          latch(8'($urandom), 1'b1);
        end
        send_row(order[i], 8'($urandom));
      end
      settle();
      checks++;
      if (bus.frame !== m_frame) begin
        failures++;
        $display("FAIL random_frame%0d got=%h want=%h", f, bus.frame, m_frame);
      end
    end
    checks++;
    if (fv_cnt !== exp_fv || re_cnt !== exp_re || be_cnt !== exp_be) begin
      failures++;
      $display("FAIL random_counts fv=%0d re=%0d be=%0d want %0d %0d %0d",
               fv_cnt, re_cnt, be_cnt, exp_fv, exp_re, exp_be);
    end
  endtask

  task automatic test_partial_reset();
    int fv0;
    for (int r = 0; r < 6; r++) send_row(r, 8'($urandom));
    do_reset();
    checks++;
    if (bus.frame !== '0) begin
      failures++;
      $display("FAIL partial_reset_frame got=%h want=0", bus.frame);
    end
    fv0 = fv_cnt;
    for (int r = 0; r < 8; r++) send_row(r, 8'hAA);
    settle();
    checks++;
    if (bus.frame !== {8{8'hAA}} || fv_cnt - fv0 !== 1) begin
      failures++;
      $display("FAIL partial_reset_full got=%h fv=%0d want all AA fv=1", bus.frame, fv_cnt - fv0);
    end
  endtask

  task automatic test_malformed();
    int re0, fv0;
    re0 = re_cnt;
    fv0 = fv_cnt;
    for (int r = 0; r < 4; r++) send_row(r, 8'($urandom));
    shift_byte(8'h00, 8);
    latch(8'h03, 1'b0);
    settle();
    checks++;
    if (re_cnt - re0 !== 1) begin
      failures++;
      $display("FAIL malformed_multihot got=%0d want=1", re_cnt - re0);
    end
    shift_byte(8'h00, 8);
    latch(8'h00, 1'b0);
    shift_byte(8'h00, 8);
    latch(8'h03, 1'b1);
    settle();
    checks++;
    if (re_cnt - re0 !== 2) begin
      failures++;
      $display("FAIL malformed_zero_oe got=%0d want=2", re_cnt - re0);
    end
    for (int r = 4; r < 8; r++) send_row(r, 8'($urandom));
    settle();
    checks++;
    if (bus.frame !== m_frame || fv_cnt - fv0 !== 1) begin
      failures++;
      $display("FAIL malformed_frame got=%h fv=%0d want=%h fv=1", bus.frame, fv_cnt - fv0, m_frame);
    end
  endtask

  task automatic test_bit_count();
    int be0;
    be0 = be_cnt;
    shift_byte(8'($urandom), 7);
    latch(8'h01, 1'b0);
    settle();
    checks++;
    if (be_cnt - be0 !== 1) begin
      failures++;
      $display("FAIL bits_short got=%0d want=1", be_cnt - be0);
    end
    shift_byte(8'($urandom), 8);
    bus.ds = 1'b1;
    drive_cycle(1'b1, 1'b0);
    latch(8'h02, 1'b0);
    shift_byte(8'($urandom), 8);
    bus.mr = 1'b0;
    tick();
    bus.mr = 1'b1;
    m_sr = '0;
    m_cnt = 0;
    tick();
    latch(8'h04, 1'b0);
    for (int r = 3; r < 8; r++) send_row(r, 8'($urandom));
    settle();
    checks++;
    if (be_cnt - be0 !== 3 || be_cnt !== exp_be) begin
      failures++;
      $display("FAIL bits_count got=%0d want=3", be_cnt - be0);
    end
    checks++;
    if (bus.frame[2] !== 8'hFF || bus.frame !== m_frame) begin
      failures++;
      $display("FAIL bits_frame got=%h want=%h", bus.frame, m_frame);
    end
  endtask

  task automatic test_duplicate();
    int fv0;
    fv0 = fv_cnt;
    send_row(2, 8'h0F);
    send_row(2, 8'hF0);
    for (int r = 0; r < 8; r++) if (r != 2) send_row(r, 8'($urandom));
    settle();
    checks++;
    if (bus.frame[2] !== 8'hF0 || fv_cnt - fv0 !== 1 || bus.frame !== m_frame) begin
      failures++;
      $display("FAIL duplicate got=%h fv=%0d want row2=F0 fv=1", bus.frame, fv_cnt - fv0);
    end
  endtask

  task automatic test_simultaneous();
    int be0;
    be0 = be_cnt;
    shift_byte(8'h5A, 8);
    bus.ds = 1'b1;
    bus.rowsIn = 8'h01;
    bus.oe = 1'b0;
    drive_cycle(1'b1, 1'b1);
    shift_byte(8'($urandom), 7);
    latch(8'h02, 1'b0);
    settle();
    checks++;
    if (be_cnt !== be0) begin
      failures++;
      $display("FAIL simul_cnt_one got=%0d want=0", be_cnt - be0);
    end
    shift_byte(8'h5A, 8);
    bus.ds = 1'b1;
    bus.rowsIn = 8'h04;
    drive_cycle(1'b1, 1'b1);
    latch(8'h08, 1'b0);
    for (int r = 4; r < 8; r++) send_row(r, 8'($urandom));
    settle();
    checks++;
    if (bus.frame[0] !== 8'hA5 || bus.frame[3] !== 8'h4A || bus.frame !== m_frame) begin
      failures++;
      $display("FAIL simul_frame got=%h want row0=A5 row3=4A", bus.frame);
    end
    checks++;
    if (be_cnt - be0 !== 1) begin
      failures++;
      $display("FAIL simul_bits_err got=%0d want=1", be_cnt - be0);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.shcp = 1'b0;
    bus.stcp = 1'b0;
    bus.mr = 1'b1;
    bus.oe = 1'b0;
    bus.ds = 1'b0;
    bus.rowsIn = 8'h00;
    mdl_clear();
    test_reset();
    test_row_sweep();
    test_random_frames();
    test_partial_reset();
    test_malformed();
    test_bit_count();
    test_duplicate();
    test_simultaneous();
    checks++;
    if (fv_cnt !== exp_fv || re_cnt !== exp_re || be_cnt !== exp_be) begin
      failures++;
      $display("FAIL final_counts fv=%0d re=%0d be=%0d want %0d %0d %0d",
               fv_cnt, re_cnt, be_cnt, exp_fv, exp_re, exp_be);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
